// File: rtl/addr_gen_2d.sv
// addr_gen_2d: two-dimensional strided address sequencer.
// A start pulse latches base/stride/row_stride/row_len/num_rows. The block
// then emits the address pattern over a valid/ready handshake, flags the
// final beat with last and pulses done once the pattern completes.
// Optional feature: define ADDR_GEN_2D_WRAP_EN to add a wrap_limit input
// that turns the address space into a circular buffer over [0, wrap_limit).
module addr_gen_2d #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    input  logic [CNT_WIDTH-1:0]  row_len,
    input  logic [CNT_WIDTH-1:0]  num_rows,
`ifdef ADDR_GEN_2D_WRAP_EN
    input  logic [ADDR_WIDTH-1:0] wrap_limit,
`endif
    input  logic                  addr_ready,
    output logic                  addr_valid,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] row_stride_q;
    logic [CNT_WIDTH-1:0]  row_len_q;
    logic [CNT_WIDTH-1:0]  num_rows_q;
    logic [ADDR_WIDTH-1:0] row_start_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  col_q;
    logic [CNT_WIDTH-1:0]  row_q;

    logic                  start_ok;
    logic                  beat;
    logic                  col_end;
    logic                  row_end;
    logic                  final_beat;
    logic                  zero_len;

`ifdef ADDR_GEN_2D_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_q;

    // Sum at one extra bit so a carry past the limit is still visible,
    // then fold back into [0, limit) with a single subtraction.
    function automatic logic [ADDR_WIDTH-1:0] step(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [ADDR_WIDTH-1:0] inc,
        input logic [ADDR_WIDTH-1:0] limit
    );
        logic [ADDR_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        if ((limit != '0) && (sum >= {1'b0, limit}))
            sum = sum - {1'b0, limit};
        return sum[ADDR_WIDTH-1:0];
    endfunction
`else
    // Natural modulo-2^ADDR_WIDTH addition.
    function automatic logic [ADDR_WIDTH-1:0] step(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [ADDR_WIDTH-1:0] inc
    );
        return a + inc;
    endfunction
`endif

    logic [ADDR_WIDTH-1:0] next_elem;
    logic [ADDR_WIDTH-1:0] next_row;

`ifdef ADDR_GEN_2D_WRAP_EN
    assign next_elem = step(addr_q, stride_q, wrap_q);
    assign next_row  = step(row_start_q, row_stride_q, wrap_q);
`else
    assign next_elem = step(addr_q, stride_q);
    assign next_row  = step(row_start_q, row_stride_q);
`endif

    assign start_ok   = start && !abort;
    assign zero_len   = (row_len == '0) || (num_rows == '0);
    assign beat       = (state == RUN) && addr_ready;
    assign col_end    = (col_q == row_len_q - CNT_WIDTH'(1));
    assign row_end    = (row_q == num_rows_q - CNT_WIDTH'(1));
    assign final_beat = col_end && row_end;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_ok) state_next = zero_len ? DONE : RUN;
            RUN: begin
                if (abort)                    state_next = IDLE;
                else if (beat && final_beat)  state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Configuration latch, address and row/column counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stride_q     <= '0;
            row_stride_q <= '0;
            row_len_q    <= '0;
            num_rows_q   <= '0;
            row_start_q  <= '0;
            addr_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
`ifdef ADDR_GEN_2D_WRAP_EN
            wrap_q       <= '0;
`endif
        end else if ((state == IDLE) && start_ok) begin
            stride_q     <= stride;
            row_stride_q <= row_stride;
            row_len_q    <= row_len;
            num_rows_q   <= num_rows;
            row_start_q  <= base_addr;
            addr_q       <= base_addr;
            col_q        <= '0;
            row_q        <= '0;
`ifdef ADDR_GEN_2D_WRAP_EN
            wrap_q       <= wrap_limit;
`endif
        end else if (beat && !abort) begin
            if (!col_end) begin
                addr_q <= next_elem;
                col_q  <= col_q + CNT_WIDTH'(1);
            end else if (!row_end) begin
                row_start_q <= next_row;
                addr_q      <= next_row;
                col_q       <= '0;
                row_q       <= row_q + CNT_WIDTH'(1);
            end
        end
    end

    // Outputs decoded from state and counters.
    always_comb begin
        addr_valid = (state == RUN);
        busy       = (state == RUN);
        done       = (state == DONE);
        last       = (state == RUN) && final_beat;
        addr_out   = addr_q;
    end

endmodule

// File: doc/addr_gen_2d.md
# addr_gen_2d

Two-dimensional strided address sequencer for the data-path controllers. It is the parametrised successor of the single-stride address register. One `start` pulse latches a base address, an element stride, a row stride, a row length and a row count. The block then emits the full address pattern over a valid/ready handshake, flags the last beat and pulses `done`. It sits between the controller FSM and memory/DMA ports that accept one address per handshake.

## Interface
- `ADDR_WIDTH`, 8, width of all addresses and strides
- `CNT_WIDTH`, 8, width of the row-length and row-count fields
- `clk`  in  1  clock, all logic on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a sequence; honoured only in IDLE
- `abort`  in  1  synchronous cancel of the current sequence
- `base_addr`  in  ADDR_WIDTH  first address, sampled on accepted `start`
- `stride`  in  ADDR_WIDTH  increment between elements within a row
- `row_stride`  in  ADDR_WIDTH  increment between row start addresses
- `row_len`  in  CNT_WIDTH  elements per row
- `num_rows`  in  CNT_WIDTH  rows per sequence
- `addr_ready`  in  1  downstream accepts `addr_out` this cycle
- `addr_valid`  out  1  `addr_out` holds a valid address
- `addr_out`  out  ADDR_WIDTH  current address
- `last`  out  1  high with the final beat of the sequence
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse at sequence completion

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start` with `abort` low latches all configuration inputs and loads `addr_out` and the row-start register with `base_addr`.
  - It clears the column counter and the row counter.
  - It goes to RUN, or directly to DONE if `row_len`==0 or `num_rows`==0 (zero beats emitted).
- **RUN**
  - `addr_valid`=1. A beat is a cycle with `addr_valid && addr_ready`.
  - On a beat that is not the last in its row: `addr_out` += `stride` and the column counter increments.
  - On a beat that is last in a row but not the last row: the row start += `row_stride`, `addr_out` gets the new row start, the column counter clears and the row counter increments.
  - On the final beat (last column of the last row): go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- Address for row r, column c = base + r·row_stride + c·stride, truncated to ADDR_WIDTH (mod 2^ADDR_WIDTH without the configuration macro).
- `last` = RUN && column==row_len-1 && row==num_rows-1. It is combinational from state and counters.
- Configuration inputs are ignored while not in IDLE. Changing them mid-sequence has no effect.
- `start` in RUN or DONE is ignored and not queued.
- `abort` in RUN or DONE: go to IDLE next cycle. `addr_valid` drops, no `done` pulse, and a beat in the same cycle is discarded. `abort` in IDLE suppresses `start`.
- While `addr_valid`=1 and `addr_ready`=0, `addr_out` and `last` stay stable. `addr_valid` never drops without a beat except on `abort` or reset.

## Timing
- Reset values: `addr_out`=0, `addr_valid`=0, `last`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- `start` sampled at edge N: `addr_valid`=1 with `addr_out`=`base_addr` from cycle N+1.
- With `addr_ready` held high: one address per cycle, no bubbles, including across row boundaries.
- Final beat at edge M: `addr_valid`=0 and `done`=1 in cycle M+1. IDLE from M+2, so the earliest new `start` is sampled at edge M+2.
- Zero-length sequence: `done` in cycle N+1, no valid beats.
- Reset asserted mid-operation clears everything immediately (asynchronous). No `done` is produced.

## Configuration
- Macro: `ADDR_GEN_2D_WRAP_EN`.
- **Defined**
  - Adds input `wrap_limit` (ADDR_WIDTH), latched on `start`.
  - Every computed next address (element and row start) is formed at ADDR_WIDTH+1 bits.
  - If the result ≥ `wrap_limit`, `wrap_limit` is subtracted once. This gives a circular buffer over [0, wrap_limit).
  - `wrap_limit`==0 disables wrapping.
  - Correct results require `base_addr`, `stride` and `row_stride` < `wrap_limit`.
- **Not defined**: no `wrap_limit` port; addresses wrap naturally mod 2^ADDR_WIDTH.

## Test plan
- **Basic 2D pattern:** base=0x10, stride=2, row_stride=0x20, row_len=3, num_rows=2, ready=1 → 0x10,0x12,0x14,0x30,0x32,0x34 on consecutive cycles. `last` on 0x34, `done` the next cycle.
- **Backpressure:** same configuration, `addr_ready` toggling 1,0,0,1… → no address skipped or repeated, `addr_out` stable during stalls, same six values.
- **Zero length and ignored start:** row_len=0 → `done` one cycle after `start`, `addr_valid` never high. A second `start` during RUN is ignored and the sequence is unchanged.
- **Abort:** `abort` on the third beat of the basic pattern → `addr_valid`=0 next cycle, no `done`. A new `start` two cycles later restarts at base.
- **Reset mid-sequence:** `reset` low during RUN → all outputs 0 immediately. After release, `start` runs normally.
- **Wrap (macro defined):** wrap_limit=0x40, base=0x3C, stride=2, row_stride=0x08, row_len=3, num_rows=2 → 0x3C,0x3E,0x00,0x04,0x06,0x08. **Macro undefined, ADDR_WIDTH=8:** base=0xFE, stride=1, row_len=3, num_rows=1 → 0xFE,0xFF,0x00.
